// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-side datapath stage behind the multi-cycle control unit.
// Holds MAR, MDR and a read buffer (RDBUF). Runs req/ready transactions to external
// word memory, and raises busy while one is outstanding so the control unit holds.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus_in                internal bus value, source for MAR/MDR loads
//   mar_wr, mdr_wr        register load strobes (IDLE only)
//   mdr_src               MDR load source: 0 = bus_in, 1 = RDBUF
//   mem_rd, mem_wr        start a read / write at MAR
//   mdr_oe, mem_oe        drive MDR / RDBUF onto bus_out
//   err_clr               clear sticky error flags
//   bus_out, bus_oe       data toward internal bus and its valid
//   busy                  transaction outstanding
//   rd_valid              one-cycle pulse after RDBUF is updated by a completed read
//   err, err_code         sticky flags: [0] misaligned, [1] timeout, [2] protocol
//   mem_req, mem_we       external request and direction
//   mem_addr, mem_wdata   MAR / MDR toward memory
//   mem_ready, mem_rdata  memory handshake and read data
module mem_access_unit #(
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] bus_in,
  input  logic          mar_wr,
  input  logic          mdr_wr,
  input  logic          mdr_src,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic          mdr_oe,
  input  logic          mem_oe,
  input  logic          err_clr,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  output logic          busy,
  output logic          rd_valid,
  output logic          err,
  output logic [2:0]    err_code,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e        state_q;
  logic [DW-1:0] mar_q, mdr_q, rdbuf_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    err_q;
  logic          we_q;
  logic          rd_valid_q;

  logic          in_idle, in_req;
  logic [DW-1:0] mar_nx;
  logic          cmd_go, cmd_conflict, misaligned, timeout_hit;
  logic [2:0]    err_set;

  assign in_idle = (state_q == StIdle);
  assign in_req  = (state_q == StReq);

  // Alignment is judged on the MAR value the access will actually use.
  assign mar_nx       = mar_wr ? bus_in : mar_q;
  assign cmd_go       = mem_rd ^ mem_wr;
  assign cmd_conflict = mem_rd & mem_wr;
  assign misaligned   = |mar_nx[1:0];
  // Last permitted wait cycle: the counter reaches TIMEOUT on this edge.
  assign timeout_hit  = in_req & ~mem_ready & (cnt_q == CW'(TIMEOUT - 1));

  assign err_set[0] = in_idle & cmd_go & misaligned;
  assign err_set[1] = timeout_hit;
  assign err_set[2] = (in_idle & cmd_conflict)
                    | (in_req & (mar_wr | mdr_wr | mem_rd | mem_wr))
                    | (mdr_oe & mem_oe);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mar_q      <= '0;
      mdr_q      <= '0;
      rdbuf_q    <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      we_q       <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      // A flag raised in the same cycle as err_clr survives the clear.
      err_q      <= (err_clr ? 3'b000 : err_q) | err_set;
      unique case (state_q)
        StIdle: begin
          if (mar_wr) mar_q <= bus_in;
          if (mdr_wr) mdr_q <= mdr_src ? rdbuf_q : bus_in;
          if (cmd_go && !misaligned) begin
            state_q <= StReq;
            we_q    <= mem_wr;
            cnt_q   <= '0;
          end
        end
        StReq: begin
          if (mem_ready) begin
            if (!we_q) begin
              rdbuf_q    <= mem_rdata;
              rd_valid_q <= 1'b1;
            end
            state_q <= StIdle;
          end else if (timeout_hit) begin
            if (!we_q) rdbuf_q <= '1;
            cnt_q   <= cnt_q + CW'(1);
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = in_req;
  assign mem_req   = in_req;
  assign mem_we    = we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign rd_valid  = rd_valid_q;
  assign err_code  = err_q;
  assign err       = |err_q;

  // MDR has priority when both output enables are raised.
  assign bus_oe  = mdr_oe | mem_oe;
  assign bus_out = mdr_oe ? mdr_q : (mem_oe ? rdbuf_q : '0);

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] bus_in = '0;
  logic          mar_wr = 0, mdr_wr = 0, mdr_src = 0, mem_rd = 0, mem_wr = 0;
  logic          mdr_oe = 0, mem_oe = 0, err_clr = 0, mem_ready = 0;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] bus_out, mem_addr, mem_wdata;
  logic          bus_oe, busy, rd_valid, err, mem_req, mem_we;
  logic [2:0]    err_code;

  mem_access_unit #(.DW(DW), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_in    (bus_in),
    .mar_wr    (mar_wr),
    .mdr_wr    (mdr_wr),
    .mdr_src   (mdr_src),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mdr_oe    (mdr_oe),
    .mem_oe    (mem_oe),
    .err_clr   (err_clr),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .busy      (busy),
    .rd_valid  (rd_valid),
    .err       (err),
    .err_code  (err_code),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            waits;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];  // expected read data, pushed at command issue

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_err();
    err_clr = 1;
    tick();
    err_clr = 0;
  endtask

  task automatic load_mar(input logic [DW-1:0] a);
    bus_in = a; mar_wr = 1; tick(); mar_wr = 0;
  endtask

  task automatic load_mdr(input logic [DW-1:0] d);
    bus_in = d; mdr_wr = 1; mdr_src = 0; tick(); mdr_wr = 0;
  endtask

  task automatic do_access(input vec_t v);
    int busy_cnt;
    bit done;
    logic [DW-1:0] exp;
    load_mar(v.addr);
    if (v.wr) load_mdr(v.wdata);
    if (v.wr) mem_wr = 1;
    else begin
      mem_rd = 1;
      sb.push_back(v.rdata);
    end
    tick();
    mem_rd = 0; mem_wr = 0;
    check("req_start", {31'd0, mem_req}, 1);
    check("mem_addr", mem_addr, v.addr);
    check("mem_we", {31'd0, mem_we}, {31'd0, v.wr});
    if (v.wr) check("mem_wdata", mem_wdata, v.wdata);
    busy_cnt = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      done      = (c == v.waits);
      mem_ready = done;
      mem_rdata = done ? v.rdata : (32'hBAD0_0000 | DW'(c));
      if (busy) busy_cnt++;
      tick();
    end
    mem_ready = 0;
    check("busy_cycles", DW'(busy_cnt), DW'(v.waits + 1));
    check("req_end", {31'd0, mem_req}, 0);
    check("rd_valid", {31'd0, rd_valid}, {31'd0, ~v.wr});
    if (rd_valid) begin
      if (sb.size() == 0) check("sb_nonempty", 0, 1);
      else begin
        exp = sb.pop_front();
        mem_oe = 1;
        #1;
        check("rdbuf", bus_out, exp);
        mem_oe = 0;
      end
    end
    tick();
    check("rd_valid_once", {31'd0, rd_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   busy_cnt;
    bit   saw_rv;
    vecs[0] = '{addr: 32'h20, wr: 1, wdata: 32'h1234_5678, rdata: 0, waits: 3};
    vecs[1] = '{addr: 32'h24, wr: 0, wdata: 0, rdata: 32'hCAFE_F00D, waits: 14};
    vecs[2] = '{addr: 32'h28, wr: 1, wdata: 32'hA5A5_5A5A, rdata: 0, waits: 0};
    vecs[3] = '{addr: 32'hFFFF_FFFC, wr: 0, wdata: 0, rdata: 32'h1357_9BDF, waits: 2};
    vecs[4] = '{addr: 32'h10, wr: 0, wdata: 0, rdata: 32'hDEAD_BEEF, waits: 0};

    // Reset state
    #12;
    check("rst_mem_req", {31'd0, mem_req}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_err_code", {29'd0, err_code}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_bus_oe", {31'd0, bus_oe}, 0);
    check("rst_bus_out", bus_out, 0);
    rst_n = 1;
    tick();

    foreach (vecs[i]) do_access(vecs[i]);
    check("err_after_table", {31'd0, err}, 0);

    // MDR load from RDBUF
    mdr_wr = 1; mdr_src = 1; tick(); mdr_wr = 0; mdr_src = 0;
    mdr_oe = 1; #1;
    check("mdr_from_rdbuf", bus_out, 32'hDEAD_BEEF);
    check("bus_oe_mdr", {31'd0, bus_oe}, 1);
    mdr_oe = 0;

    // Read timeout: 15 wait cycles, then abort
    load_mar(32'h30);
    mem_rd = 1; tick(); mem_rd = 0;
    busy_cnt = 0; saw_rv = 0;
    for (int c = 0; c < 40; c++) begin
      if (rd_valid) saw_rv = 1;
      if (!busy) break;
      busy_cnt++;
      tick();
    end
    check("timeout_busy", DW'(busy_cnt), 15);
    check("timeout_no_rv", {31'd0, saw_rv}, 0);
    check("timeout_code", {29'd0, err_code}, 3'b010);
    mem_oe = 1; #1;
    check("timeout_rdbuf", bus_out, 32'hFFFF_FFFF);
    mem_oe = 0;
    clear_err();
    check("err_cleared", {31'd0, err}, 0);

    // Misaligned address loaded in the same cycle as the command
    bus_in = 32'h22; mar_wr = 1; mem_rd = 1; tick(); mar_wr = 0; mem_rd = 0;
    check("misalign_req", {31'd0, mem_req}, 0);
    check("misalign_code", {29'd0, err_code}, 3'b001);
    clear_err();

    // Conflicting commands, raised together with err_clr: flag wins
    load_mar(32'h40);
    mem_rd = 1; mem_wr = 1; err_clr = 1; tick();
    mem_rd = 0; mem_wr = 0; err_clr = 0;
    check("conflict_req", {31'd0, mem_req}, 0);
    check("conflict_code", {29'd0, err_code}, 3'b100);
    clear_err();

    // Both output enables
    load_mdr(32'h0BAD_F00D);
    mdr_oe = 1; mem_oe = 1; #1;
    check("both_oe_out", bus_out, 32'h0BAD_F00D);
    tick();
    mdr_oe = 0; mem_oe = 0;
    check("both_oe_code", {29'd0, err_code}, 3'b100);
    clear_err();

    // MAR write attempted during REQ
    load_mar(32'h50);
    mem_rd = 1; tick(); mem_rd = 0;
    bus_in = 32'h40; mar_wr = 1; tick(); mar_wr = 0;
    check("guard_addr_mid", mem_addr, 32'h50);
    mem_ready = 1; mem_rdata = 32'h7777_0000; tick(); mem_ready = 0;
    check("guard_addr_after", mem_addr, 32'h50);
    check("guard_code", {29'd0, err_code}, 3'b100);
    check("guard_rv", {31'd0, rd_valid}, 1);
    clear_err();

    // Asynchronous reset during REQ
    load_mar(32'h60);
    mem_rd = 1; tick(); mem_rd = 0;
    check("pre_rst_req", {31'd0, mem_req}, 1);
    rst_n = 0; #1;
    check("arst_mem_req", {31'd0, mem_req}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_mar", mem_addr, 0);
    mem_oe = 1; #1;
    check("arst_rdbuf", bus_out, 0);
    mem_oe = 0;
    rst_n = 1;
    tick();
    do_access('{addr: 32'h64, wr: 0, wdata: 0, rdata: 32'h2468_ACE0, waits: 1});
    check("sb_drained", DW'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side datapath stage downstream of the multi-cycle control unit.
- Holds the MAR and the MDR, and consumes the control unit's memory strobes (mar_wr, mdr_wr, mdr_src, mem_rd, mem_wr, mdr_oe, mem_oe).
- Runs variable-latency req/ready transactions to external word memory and returns read data to the internal bus.
- Raises busy to stall the control unit while a transaction is outstanding.

Parameters:
- DW, 32, data and address width.
- TIMEOUT, 15, maximum REQ cycles without mem_ready before the access is aborted.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bus_in  in  DW  internal bus value, source for MAR/MDR loads.
- mar_wr  in  1  load MAR from bus_in.
- mdr_wr  in  1  load MDR.
- mdr_src  in  1  MDR load source: 0 = bus_in, 1 = read buffer (RDBUF).
- mem_rd  in  1  start read at MAR.
- mem_wr  in  1  start write of MDR to MAR.
- mdr_oe  in  1  drive MDR onto bus_out.
- mem_oe  in  1  drive RDBUF onto bus_out.
- err_clr  in  1  clear sticky error flags.
- bus_out  out  DW  data toward internal bus.
- bus_oe  out  1  bus_out valid.
- busy  out  1  transaction outstanding; control unit must hold its state.
- rd_valid  out  1  one-cycle pulse: RDBUF updated by a completed read.
- err  out  1  OR of the sticky error flags.
- err_code  out  3  sticky flags: [0] misaligned, [1] timeout, [2] protocol violation.
- mem_req  out  1  request to external memory.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  DW  equals MAR while mem_req is high.
- mem_wdata  out  DW  equals MDR while mem_req is high.
- mem_ready  in  1  memory accepts the request / read data valid this cycle.
- mem_rdata  in  DW  read data, sampled when mem_req && mem_ready.

Behaviour:
- Reset: the following clear asynchronously to 0 and the FSM enters IDLE:
  - registers: MAR, MDR, RDBUF, timeout counter, err_code;
  - outputs: mem_req, mem_we, rd_valid, busy.
  - Reset during REQ drops mem_req immediately and no data is captured.
- FSM states: IDLE, REQ. busy = (state == REQ). mem_req = (state == REQ).
- Register loads, IDLE only:
  - mar_wr: MAR <= bus_in.
  - mdr_wr with mdr_src = 0: MDR <= bus_in.
  - mdr_wr with mdr_src = 1: MDR <= RDBUF.
  - Loads in the same cycle as a command take effect first, so the access uses the newly loaded values.
- IDLE -> REQ on mem_rd xor mem_wr:
  - mem_we latches mem_wr; the timeout counter clears.
  - Precondition: MAR[1:0] = 00, evaluated after any same-cycle mar_wr.
  - If MAR[1:0] != 00, set err_code[0] and stay in IDLE.
- mem_rd and mem_wr together in IDLE: set err_code[2]; no transaction.
- REQ, mem_ready = 1:
  - Read: RDBUF <= mem_rdata, and rd_valid pulses high the next cycle.
  - Write: transaction complete.
  - Return to IDLE in either case.
- REQ, mem_ready = 0: counter increments.
  - When the counter reaches TIMEOUT (TIMEOUT REQ cycles without ready): set err_code[1].
  - On a read timeout, RDBUF <= all ones; rd_valid is not pulsed.
  - Return to IDLE.
- Latency: command at edge k puts mem_req high in cycle k+1.
  - Zero-wait ready in cycle k+1 makes RDBUF valid after edge k+2.
  - busy is high for (1 + wait cycles).
- Strobes during REQ:
  - mar_wr, mdr_wr, mem_rd, mem_wr are ignored and set err_code[2]; MAR/MDR stay stable for the whole access.
  - mdr_oe and mem_oe are still honoured.
- Bus output is combinational:
  - bus_oe = mdr_oe | mem_oe.
  - mdr_oe selects MDR; mem_oe alone selects RDBUF.
  - Both high: bus_out = MDR and err_code[2] is set.
  - bus_out = 0 when bus_oe = 0.
- err_code bits are sticky.
  - err_clr clears them next edge.
  - A flag raised in the same cycle as err_clr wins (stays set).
- The timeout counter is ceil(log2(TIMEOUT+1)) bits and never wraps.

Test Plan:
- Zero-wait read: bus_in = 0x00000010 with mar_wr; next cycle mem_rd; memory ready immediately with rdata 0xDEADBEEF -> mem_req high exactly 1 cycle, mem_addr = 0x10, rd_valid pulse, mem_oe gives bus_out = 0xDEADBEEF, mdr_wr with mdr_src = 1 loads MDR = 0xDEADBEEF.
- Write with 3 wait cycles: MAR = 0x20, MDR = 0x12345678 via bus, mem_wr; ready on 4th REQ cycle -> mem_we = 1, mem_wdata = 0x12345678, busy high 4 cycles, no rd_valid, err = 0.
- Timeout: read with mem_ready held 0 -> after 15 REQ cycles err_code = 010, RDBUF = 0xFFFFFFFF, FSM in IDLE; err_clr -> err = 0.
- Misaligned and conflicting commands:
  - MAR = 0x22 with mem_rd -> no mem_req, err_code[0] set.
  - mem_rd and mem_wr together -> err_code[2] set, no request.
  - mdr_oe and mem_oe together -> bus_out = MDR, err_code[2] set.
- Protocol guard: mar_wr with bus_in = 0x40 during REQ -> mem_addr unchanged for the whole access, err_code[2] set.
- Reset mid-read: rst_n low during REQ -> mem_req, busy, MAR, RDBUF all 0 without a clock edge; after release a new read completes normally.
